// File: rtl/shift_seq8.sv
// Multi-cycle 8-bit shifter/rotator: consumes the shift amount up to 3 bits per
// cycle, exposing intermediate values on d_out and pulsing done with the result.
module shift_seq8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [2:0] amt,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;

  state_t     state;
  logic [7:0] data;
  logic [2:0] rem;
  logic [1:0] op_r;
  logic [2:0] step;
  logic [2:0] rem_nxt;

  // One shifter stage; s never exceeds 3 in practice but any 0-7 is handled.
  function automatic logic [7:0] shift_step(input logic [7:0] x,
                                            input logic [1:0] o,
                                            input logic [2:0] s);
    logic signed [7:0] sx;
    logic [15:0]       rot;
    sx  = x;
    rot = {x, x} >> s;
    case (o)
      OP_LSL:  return x << s;
      OP_LSR:  return x >> s;
      OP_ASR:  return $unsigned(sx >>> s);
      default: return rot[7:0];
    endcase
  endfunction

  always_comb begin
    step    = (rem > 3'd3) ? 3'd3 : rem;
    rem_nxt = rem - step;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      data  <= 8'h00;
      rem   <= 3'd0;
      op_r  <= 2'b00;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            data <= d_in;
            rem  <= amt;
            op_r <= op;
            busy <= 1'b1;
            if (amt == 3'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SHIFT;
              done  <= 1'b0;
            end
          end
        end
        SHIFT: begin
          data <= shift_step(data, op_r, step);
          rem  <= rem_nxt;
          if (rem_nxt == 3'd0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign d_out = data;

endmodule

// File: doc/shift_seq8.md
SHIFT_SEQ8 -- requirements
Module: shift_seq8

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request a shift; sampled only in IDLE.
REQ-005 Port: op  input  2  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROR; captured with start.
REQ-006 Port: amt  input  3  total shift amount, 0-7; captured with start.
REQ-007 Port: d_in  input  8  operand; captured with start.
REQ-008 Port: d_out  output  8  working/result register, always driven from the register.
REQ-009 Port: busy  output  1  high whenever the state is not IDLE.
REQ-010 Port: done  output  1  one-cycle pulse; d_out is valid as the result while done=1.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 IDLE with start=1 at a rising edge SHALL load data<=d_in, rem<=amt and op_r<=op.
REQ-013 On that edge the next state SHALL be SHIFT if amt!=0, and DONE if amt==0.
REQ-014 IDLE with start=0 SHALL hold all registers and stay in IDLE.
REQ-015 Each SHIFT edge SHALL shift data by step=min(rem,3) using op_r.
REQ-016 Each SHIFT edge SHALL update rem<=rem-step.
REQ-017 SHIFT SHALL go to DONE when rem-step==0, and otherwise stay in SHIFT.
REQ-018 Shift semantics SHALL be as follows:
  - LSL: zero-fill from bit 0.
  - LSR: zero-fill from bit 7.
  - ASR: bit 7 replicated, so each step matches a 2-bit arithmetic-right mux stage.
  - ROR: bits leaving bit 0 re-enter at bit 7.
REQ-019 The step and rem arithmetic SHALL be 3-bit unsigned, and rem SHALL never underflow.
REQ-020 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE on the next edge.
REQ-021 Data SHALL be unchanged in the DONE state.
REQ-022 Latency SHALL be as follows:
  - done high during the cycle beginning ceil(amt/3)+1 edges after the start edge.
  - amt=0: 1 edge; amt=1-3: 2; amt=4-6: 3; amt=7: 4.
REQ-023 busy SHALL be 0 in IDLE and 1 in SHIFT and DONE; done SHALL be 1 only in DONE.
REQ-024 start SHALL be ignored while busy=1, with no capture, no restart and no queuing.
REQ-025 start=1 in the IDLE cycle right after DONE SHALL be accepted normally, giving back-to-back operation.
REQ-026 d_out SHALL hold the last result in IDLE until the next accepted start.
REQ-027 d_out SHALL show intermediate values during SHIFT.

Reset
REQ-028 reset=1 at a rising edge SHALL force state=IDLE, data=8'h00, rem=0, op_r=00.
REQ-029 While reset=1 the outputs SHALL be d_out=8'h00, busy=0, done=0.
REQ-030 Reset SHALL take priority over start and over any in-flight SHIFT or DONE.
REQ-031 A reset mid-operation SHALL abort the operation with no done pulse.
REQ-032 The first start after reset deasserts SHALL be accepted normally.

Verification
REQ-033 ASR, d_in=8'h96, amt=5, start 1 cycle:
  - busy=1 for 3 cycles.
  - Steps 3 then 2.
  - Intermediate d_out=8'hF2.
  - Final d_out=8'hFC with done on the 3rd edge after start.
REQ-034 LSL, d_in=8'h81, amt=7: steps 3,3,1; d_out=8'h80; done after 4 edges.
REQ-035 LSR 8'hF0 by 4 -> 8'h0F.
REQ-036 ROR 8'h81 by 1 -> 8'hC0, with done after 2 edges.
REQ-037 amt=0, d_in=8'h5A -> next edge DONE with d_out=8'h5A, done=1 for one cycle.
REQ-038 Second start (d_in=8'hFF) raised mid-SHIFT -> ignored; the first result is unaffected.
REQ-039 Start accepted the cycle after done -> back-to-back results are correct.
REQ-040 reset asserted in the second SHIFT cycle of an amt=7 operation:
  - Next edge: d_out=8'h00, busy=0, no done pulse.
  - A subsequent start works normally.
